// File: rtl/fpu_add_sub_pipe.sv
// Three-stage pipelined IEEE-754-style adder/subtractor with valid/ready flow control.
// Stages: unpack/align, add and normalise, round/pack; subnormal operands flush to zero.
module fpu_add_sub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     num1,
   input  logic [EXP_W+MAN_W:0]     num2,
   input  logic                     op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     S,
   output logic [3:0]               flags
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int MW  = MAN_W + 4;
   localparam int EXW = EXP_W + 2;
   localparam int LZW = $clog2(MW + 1);

   localparam logic [EXP_W-1:0]     EXP_ONES = '1;
   localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic signed [EXW-1:0] EXP_MAX = EXW'((1 << EXP_W) - 1);
   localparam logic signed [EXW-1:0] EXP_ONE = EXW'(1);

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // ---------------------------------------------------------------- stage 1
   logic [W-1:0]           opnd   [2];
   logic                   u_sign [2];
   logic [EXP_W-1:0]       u_exp  [2];
   logic [MAN_W:0]         u_man  [2];
   logic                   u_nan  [2];
   logic                   u_snan [2];
   logic                   u_inf  [2];
   logic [EXP_W+MAN_W-1:0] u_mag  [2];

   assign opnd[0] = num1;
   assign opnd[1] = {num2[W-1] ^ op, num2[W-2:0]};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unpack
         logic [EXP_W-1:0] e;
         logic [MAN_W-1:0] f;
         logic             z;
         assign e            = opnd[gi][W-2:MAN_W];
         assign f            = opnd[gi][MAN_W-1:0];
         assign z            = (e == '0);
         assign u_sign[gi]   = opnd[gi][W-1];
         assign u_exp[gi]    = z ? '0 : e;
         assign u_man[gi]    = z ? '0 : {1'b1, f};
         assign u_nan[gi]    = (e == EXP_ONES) && (f != '0);
         assign u_snan[gi]   = (e == EXP_ONES) && (f != '0) && !f[MAN_W-1];
         assign u_inf[gi]    = (e == EXP_ONES) && (f == '0);
         assign u_mag[gi]    = z ? '0 : {e, f};
      end
   endgenerate

   logic             swap;
   logic             big_sign;
   logic             small_sign;
   logic [EXP_W-1:0] big_exp;
   logic [EXP_W-1:0] small_exp;
   logic [MAN_W:0]   big_man;
   logic [MAN_W:0]   small_man;

   assign swap       = u_mag[1] > u_mag[0];
   assign big_sign   = swap ? u_sign[1] : u_sign[0];
   assign small_sign = swap ? u_sign[0] : u_sign[1];
   assign big_exp    = swap ? u_exp[1]  : u_exp[0];
   assign small_exp  = swap ? u_exp[0]  : u_exp[1];
   assign big_man    = swap ? u_man[1]  : u_man[0];
   assign small_man  = swap ? u_man[0]  : u_man[1];

   logic [EXP_W-1:0] shift_d;
   logic [MW-1:0]    small_ext;
   logic [MW-1:0]    lost_mask;
   logic [MW-1:0]    aligned;
   logic             sticky;

   always_comb begin
      shift_d   = big_exp - small_exp;
      small_ext = {small_man, 3'b000};
      lost_mask = ~({MW{1'b1}} << shift_d);
      aligned   = '0;
      sticky    = 1'b0;
      if (32'(shift_d) >= MW - 1) begin
         aligned = '0;
         sticky  = |small_ext;
      end else begin
         aligned = small_ext >> shift_d;
         sticky  = |(small_ext & lost_mask);
      end
      aligned[0] = aligned[0] | sticky;
   end

   logic         spec;
   logic [W-1:0] spec_val;
   logic         spec_nv;

   assign spec = u_nan[0] || u_nan[1] || u_inf[0] || u_inf[1];

   always_comb begin
      spec_val = QNAN;
      spec_nv  = 1'b0;
      if (u_nan[0] || u_nan[1]) begin
         spec_val = QNAN;
         spec_nv  = u_snan[0] || u_snan[1];
      end else if (u_inf[0] && u_inf[1] && (u_sign[0] != u_sign[1])) begin
         spec_val = QNAN;
         spec_nv  = 1'b1;
      end else if (u_inf[0]) begin
         spec_val = {u_sign[0], EXP_ONES, {MAN_W{1'b0}}};
      end else begin
         spec_val = {u_sign[1], EXP_ONES, {MAN_W{1'b0}}};
      end
   end

   logic             s1_valid_reg;
   logic             s1_spec_reg;
   logic [W-1:0]     s1_spec_val_reg;
   logic             s1_spec_nv_reg;
   logic             s1_sign_reg;
   logic             s1_sub_reg;
   logic [EXP_W-1:0] s1_exp_reg;
   logic [MW-1:0]    s1_m_big_reg;
   logic [MW-1:0]    s1_m_small_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_reg    <= 1'b0;
         s1_spec_reg     <= 1'b0;
         s1_spec_val_reg <= '0;
         s1_spec_nv_reg  <= 1'b0;
         s1_sign_reg     <= 1'b0;
         s1_sub_reg      <= 1'b0;
         s1_exp_reg      <= '0;
         s1_m_big_reg    <= '0;
         s1_m_small_reg  <= '0;
      end else if (adv) begin
         s1_valid_reg    <= in_valid;
         s1_spec_reg     <= spec;
         s1_spec_val_reg <= spec_val;
         s1_spec_nv_reg  <= spec_nv;
         s1_sign_reg     <= big_sign;
         s1_sub_reg      <= big_sign ^ small_sign;
         s1_exp_reg      <= big_exp;
         s1_m_big_reg    <= {big_man, 3'b000};
         s1_m_small_reg  <= aligned;
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [MW:0]             sum;
   logic [LZW-1:0]          lzc;
   logic [MW-1:0]           norm;
   logic signed [EXW-1:0]   exp_n;
   logic                    sum_zero;
   logic                    sign_n;

   assign sum = s1_sub_reg ? ({1'b0, s1_m_big_reg} - {1'b0, s1_m_small_reg})
                           : ({1'b0, s1_m_big_reg} + {1'b0, s1_m_small_reg});

   // Priority encoder: the highest set bit wins because it is visited last.
   always_comb begin
      lzc = LZW'(MW);
      for (int i = 0; i < MW; i++) begin
         if (sum[i]) lzc = LZW'(MW - 1 - i);
      end
   end

   always_comb begin
      sum_zero = (sum == '0);
      sign_n   = s1_sign_reg;
      if (sum[MW]) begin
         norm  = {sum[MW:2], sum[1] | sum[0]};
         exp_n = $signed({2'b00, s1_exp_reg}) + EXP_ONE;
      end else begin
         norm  = sum[MW-1:0] << lzc;
         exp_n = $signed({2'b00, s1_exp_reg}) - $signed({{(EXW-LZW){1'b0}}, lzc});
      end
      // An exact cancellation is +0; equal-signed zeros keep their sign.
      if (sum_zero) sign_n = s1_sub_reg ? 1'b0 : s1_sign_reg;
   end

   logic                  s2_valid_reg;
   logic                  s2_spec_reg;
   logic [W-1:0]          s2_spec_val_reg;
   logic                  s2_spec_nv_reg;
   logic                  s2_sign_reg;
   logic                  s2_zero_reg;
   logic signed [EXW-1:0] s2_exp_reg;
   logic [MW-1:0]         s2_mant_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_valid_reg    <= 1'b0;
         s2_spec_reg     <= 1'b0;
         s2_spec_val_reg <= '0;
         s2_spec_nv_reg  <= 1'b0;
         s2_sign_reg     <= 1'b0;
         s2_zero_reg     <= 1'b0;
         s2_exp_reg      <= '0;
         s2_mant_reg     <= '0;
      end else if (adv) begin
         s2_valid_reg    <= s1_valid_reg;
         s2_spec_reg     <= s1_spec_reg;
         s2_spec_val_reg <= s1_spec_val_reg;
         s2_spec_nv_reg  <= s1_spec_nv_reg;
         s2_sign_reg     <= sign_n;
         s2_zero_reg     <= sum_zero;
         s2_exp_reg      <= exp_n;
         s2_mant_reg     <= norm;
      end
   end

   // ---------------------------------------------------------------- stage 3
   logic [MAN_W:0]        m_keep;
   logic                  g_bit;
   logic                  r_bit;
   logic                  s_bit;
   logic                  inexact;
   logic                  rnd_up;
   logic [MAN_W+1:0]      m_rnd;
   logic [MAN_W-1:0]      frac_r;
   logic signed [EXW-1:0] exp_r;
   logic [W-1:0]          res;
   logic [3:0]            res_flags;

   assign m_keep  = s2_mant_reg[MW-1:3];
   assign g_bit   = s2_mant_reg[2];
   assign r_bit   = s2_mant_reg[1];
   assign s_bit   = s2_mant_reg[0];
   assign inexact = g_bit || r_bit || s_bit;
   assign rnd_up  = g_bit && (r_bit || s_bit || m_keep[0]);
   assign m_rnd   = {1'b0, m_keep} + (MAN_W+2)'(rnd_up);

   always_comb begin
      if (m_rnd[MAN_W+1]) begin
         frac_r = m_rnd[MAN_W:1];
         exp_r  = s2_exp_reg + EXP_ONE;
      end else begin
         frac_r = m_rnd[MAN_W-1:0];
         exp_r  = s2_exp_reg;
      end
   end

   // flags = {NV, OF, UF, NX}
   always_comb begin
      res       = '0;
      res_flags = 4'b0000;
      if (s2_spec_reg) begin
         res       = s2_spec_val_reg;
         res_flags = {s2_spec_nv_reg, 3'b000};
      end else if (s2_zero_reg) begin
         res       = {s2_sign_reg, {(W-1){1'b0}}};
      end else if (exp_r >= EXP_MAX) begin
         res       = {s2_sign_reg, EXP_ONES, {MAN_W{1'b0}}};
         res_flags = 4'b0101;
      end else if (exp_r < EXP_ONE) begin
         res       = {s2_sign_reg, {(W-1){1'b0}}};
         res_flags = 4'b0011;
      end else begin
         res       = {s2_sign_reg, exp_r[EXP_W-1:0], frac_r};
         res_flags = {3'b000, inexact};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         S         <= '0;
         flags     <= 4'b0000;
      end else if (adv) begin
         out_valid <= s2_valid_reg;
         S         <= res;
         flags     <= res_flags;
      end
   end

endmodule

// File: tb/tb_fpu_add_sub_pipe.sv
// Directed-vector bench for fpu_add_sub_pipe: latency, rounding, specials,
// back-pressure ordering and mid-flight reset.
module tb_fpu_add_sub_pipe;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] num1 = '0;
   logic [31:0] num2 = '0;
   logic        op = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] S;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;

   fpu_add_sub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .num1      (num1),
      .num2      (num2),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic o,
                        input logic [31:0] es, input logic [3:0] ef, input string tag);
      num1 = a; num2 = b; op = o; in_valid = 1'b1;
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check({tag, "_lat1"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_lat2"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_S"}, S, es);
      check({tag, "_flags"}, 32'(flags), 32'(ef));
      $display("txn %s: %h %s %h -> S=%h flags=%b", tag, a, o ? "-" : "+", b, S, flags);
   endtask

   logic [31:0] bv_a [4] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF};
   logic [31:0] bv_b [4] = '{32'h40000000, 32'h3F800000, 32'h33800001, 32'h7F7FFFFF};
   logic        bv_o [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   logic [31:0] bv_s [4] = '{32'h40400000, 32'h00000000, 32'h3F800001, 32'h7F800000};
   logic [3:0]  bv_f [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0101};

   initial begin
      int n_in;
      int n_out;
      int stall_cyc;
      int stale;
      logic        held_v;
      logic [31:0] held_s;

      #1 rstn = 1'b0;
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_S", S, 32'h0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      tick();
      rstn = 1'b1;
      tick();

      issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, "one_plus_two");
      issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, "one_minus_one");
      issue(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, "negz_plus_negz");
      issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, "tie_even");
      issue(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001, "above_tie");
      issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, "overflow");
      issue(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, "inf_minus_inf");
      issue(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, "inf_plus_fin");
      issue(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, "fin_minus_inf");
      issue(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, "qnan_in");
      issue(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, "snan_in");
      issue(32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 4'b0000, "one_minus_half");
      issue(32'h3F000000, 32'h3F800000, 1'b1, 32'hBF000000, 4'b0000, "half_minus_one");
      issue(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, "underflow");
      issue(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, "subnorm_ftz");
      issue(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001, "far_shift");
      issue(32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'b0001, "round_carry");
      issue(32'h3F7FFFFF, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000, "sum_carry");

      // Back-to-back with the consumer stalled for five cycles.
      tick();
      tick();
      n_in = 0; n_out = 0; stall_cyc = 0; held_v = 1'b0; held_s = '0;
      for (int c = 0; c < 40 && n_out < 4; c++) begin
         out_ready = !(c >= 3 && c <= 7);
         in_valid  = (n_in < 4);
         if (n_in < 4) begin
            num1 = bv_a[n_in]; num2 = bv_b[n_in]; op = bv_o[n_in];
         end
         #1;
         if (out_valid && !out_ready) begin
            stall_cyc++;
            check("b2b_in_ready_low", 32'(in_ready), 32'd0);
            if (held_v) check("b2b_S_hold", S, held_s);
            held_v = 1'b1;
            held_s = S;
         end else begin
            held_v = 1'b0;
         end
         if (out_valid && out_ready) begin
            check("b2b_S", S, bv_s[n_out]);
            check("b2b_flags", 32'(flags), 32'(bv_f[n_out]));
            $display("txn b2b[%0d]: S=%h flags=%b", n_out, S, flags);
            n_out++;
         end
         if (in_valid && in_ready) n_in++;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("b2b_delivered", 32'(n_out), 32'd4);
      check("b2b_stall_cycles", 32'(stall_cyc), 32'd5);
      tick();
      tick();

      // Reset with operations in flight.
      num1 = 32'h3F800000; num2 = 32'h40000000; op = 1'b0; in_valid = 1'b1;
      tick();
      num1 = 32'h3F800000; num2 = 32'h3F800000; op = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      check("rst2_pre_valid", 32'(out_valid), 32'd1);
      rstn = 1'b0;
      #1;
      check("rst2_out_valid", 32'(out_valid), 32'd0);
      check("rst2_S", S, 32'h0);
      check("rst2_flags", 32'(flags), 32'd0);
      check("rst2_in_ready", 32'(in_ready), 32'd1);
      tick();
      tick();
      rstn = 1'b1;
      stale = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (out_valid) stale++;
      end
      check("rst2_no_stale", 32'(stale), 32'd0);
      issue(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, "post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fpu_add_sub_pipe.md
FPU_ADD_SUB_PIPE -- requirements
Module: fpu_add_sub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 num1  input  W  operand A, IEEE-754-style {sign, exponent, fraction}.
REQ-008 num2  input  W  operand B.
REQ-009 op  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 S  output  W  result.
REQ-013 flags  output  4  {NV invalid, OF overflow, UF underflow, NX inexact}, qualified by out_valid.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 unpack, special detect, swap by magnitude, align with guard/round/sticky; S2 signed-magnitude add/subtract and leading-zero normalise; S3 round-to-nearest-even, pack, flags.
REQ-015 Latency SHALL be exactly 3 cycles from accepted input to out_valid with out_ready held high; throughput 1 op/cycle.
REQ-016 Advance condition adv = !out_valid || out_ready; all stages and their valid bits SHALL move only when adv=1; in_ready SHALL equal adv combinationally.
REQ-017 Transfer SHALL occur only on in_valid && in_ready (input) or out_valid && out_ready (output); S and flags SHALL stay stable while out_valid && !out_ready.
REQ-018 Bubbles SHALL propagate as invalid slots; no result is dropped or duplicated.
REQ-019 op=1 SHALL be implemented by inverting B's sign before S1.
REQ-020 Alignment shifts of MAN_W+3 or more SHALL yield zero aligned mantissa with sticky = OR of all shifted-out bits.
REQ-021 Subnormal inputs (exp=0) SHALL be treated as signed zero (flush-to-zero).
REQ-022 Normalisation SHALL use a leading-zero count over the full MAN_W+4 bit sum, not an iterative loop; carry-out SHALL right-shift by 1 and increment exponent.
REQ-023 Rounding SHALL be RNE on guard/round/sticky; mantissa overflow after rounding SHALL renormalise and increment exponent.
REQ-024 Result exponent >= all-ones after rounding SHALL give signed infinity, OF=1, NX=1.
REQ-025 Result exponent < 1 SHALL give signed zero, UF=1, NX=1.
REQ-026 NX SHALL be set when any of guard/round/sticky is 1.
REQ-027 Any NaN input, or inf + (-inf) effective, SHALL give canonical quiet NaN {0, all-ones, 1, zeros}; NV=1 only for inf-inf or signalling NaN input.
REQ-028 inf op finite SHALL give that inf, flags 0.
REQ-029 Exact zero result from operands of opposite effective sign SHALL be +0; (-0)+(-0) SHALL be -0.

Reset
REQ-030 On rstn=0, all stage valid bits, out_valid, S and flags SHALL clear to 0 asynchronously; in_ready SHALL read 1 during and after reset.
REQ-031 In-flight operations at reset SHALL be discarded; first output after rstn release SHALL belong to an input accepted after release.

Verification
REQ-032 num1=0x3F800000, num2=0x40000000, op=0, out_ready=1 -> S=0x40400000, flags=0, out_valid exactly 3 cycles later.
REQ-033 num1=0x3F800000, num2=0x3F800000, op=1 -> S=0x00000000, flags=0; num1=num2=0x80000000, op=0 -> S=0x80000000.
REQ-034 num1=0x3F800000, num2=0x33800000, op=0 (tie) -> S=0x3F800000, NX=1; num2=0x33800001 -> S=0x3F800001, NX=1.
REQ-035 num1=num2=0x7F7FFFFF, op=0 -> S=0x7F800000, flags=OF|NX; num1=0x7F800000, num2=0x7F800000, op=1 -> S=0x7FC00000, NV=1.
REQ-036 4 back-to-back inputs, out_ready low for cycles 3-7 -> in_ready low while out_valid && !out_ready, S held constant, all 4 results delivered in order with no loss after out_ready rises.
REQ-037 rstn pulsed low with 2 ops in flight -> out_valid=0 immediately, no stale result after release, next accepted op returns correct result in 3 cycles.
